// File: rtl/control_pkg.sv
// Shared encodings for the Mini-SRC hardwired control sequencer: state
// enum, opcode values, op-class helpers and the ALU select rule.
package control_pkg;

   // Sequencer states. IDLE waits for run, T0-T2 fetch, T3-T6 execute,
   // HALT is terminal until clear.
   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_HALT = 4'd8
   } state_e;

   // Opcodes (IR[31:27]) understood by this sequencer.
   localparam logic [4:0] OP_ADD  = 5'd1;
   localparam logic [4:0] OP_SUB  = 5'd2;
   localparam logic [4:0] OP_AND  = 5'd3;
   localparam logic [4:0] OP_OR   = 5'd4;
   localparam logic [4:0] OP_SHR  = 5'd5;
   localparam logic [4:0] OP_SHL  = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;
   localparam logic [4:0] OP_HALT = 5'd27;

   // Two-source ALU ops that write their result back to ra.
   function automatic logic is_binary(input logic [4:0] op);
      return (op >= OP_ADD) && (op <= OP_ROL);
   endfunction

   // One-source ALU ops (rb only) that write their result back to ra.
   function automatic logic is_unary(input logic [4:0] op);
      return (op == OP_NEG) || (op == OP_NOT);
   endfunction

   // Two-source ops whose 64-bit result lands in HI/LO.
   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   // The ALU select is the opcode shifted down by one (add -> 0, sub -> 1).
   function automatic logic [4:0] alu_code(input logic [4:0] op);
      return op - 5'd1;
   endfunction

endpackage

// File: rtl/control_unit_ir_decoder.sv
// Combinational instruction-register field decoder: splits IR into the
// opcode and one-hot register selects, and classifies the opcode.
module ir_decoder
   import control_pkg::*;
(
   input  logic [31:0] IR,
   output logic [4:0]  opcode,
   output logic [15:0] ra_sel,
   output logic [15:0] rb_sel,
   output logic [15:0] rc_sel,
   output logic        op_binary,
   output logic        op_unary,
   output logic        op_muldiv,
   output logic        op_halt,
   output logic        illegal_op
);

   logic [3:0] ra_idx;
   logic [3:0] rb_idx;
   logic [3:0] rc_idx;
   logic       unused_ir_bits;

   assign opcode = IR[31:27];
   assign ra_idx = IR[26:23];
   assign rb_idx = IR[22:19];
   assign rc_idx = IR[18:15];

   // The low IR bits carry immediates for instructions not handled here.
   assign unused_ir_bits = ^IR[14:0];

   // 4-to-16 one-hot decode of each register field.
   always_comb begin
      ra_sel = 16'd0;
      rb_sel = 16'd0;
      rc_sel = 16'd0;
      ra_sel[ra_idx] = 1'b1;
      rb_sel[rb_idx] = 1'b1;
      rc_sel[rc_idx] = 1'b1;
   end

   // Opcode classification; anything outside the known set is illegal.
   always_comb begin
      op_binary  = is_binary(opcode);
      op_unary   = is_unary(opcode);
      op_muldiv  = is_muldiv(opcode);
      op_halt    = (opcode == OP_HALT);
      illegal_op = !(op_binary || op_unary || op_muldiv || op_halt);
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Phase-1 Mini-SRC datapath.
// Fetches each instruction in T0-T2 and executes the register-register
// ALU subset in T3-T6. Strobes are a decode of the state register plus
// the IR fields, which the datapath holds stable from T3 until the
// instruction completes. state_dbg exposes the current state.
module control_unit
   import control_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] IR,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic [4:0]  ALU_Control,
   output logic        instr_done,
   output logic        illegal,
   output logic        halted,
   output state_e      state_dbg
);

   state_e      state;
   logic [4:0]  opcode;
   logic [15:0] ra_sel;
   logic [15:0] rb_sel;
   logic [15:0] rc_sel;
   logic        op_binary;
   logic        op_unary;
   logic        op_muldiv;
   logic        op_halt;
   logic        illegal_op;
   logic        op_alu;
   logic        op_two_src;

   ir_decoder u_ir_decoder (
      .IR         (IR),
      .opcode     (opcode),
      .ra_sel     (ra_sel),
      .rb_sel     (rb_sel),
      .rc_sel     (rc_sel),
      .op_binary  (op_binary),
      .op_unary   (op_unary),
      .op_muldiv  (op_muldiv),
      .op_halt    (op_halt),
      .illegal_op (illegal_op)
   );

   // op_alu: result goes back to ra. op_two_src: second operand is rc.
   assign op_alu     = op_binary || op_unary;
   assign op_two_src = op_binary || op_muldiv;

   assign state_dbg = state;
   assign halted    = (state == ST_HALT);

   // State register and sticky illegal flag. run is only consulted in
   // IDLE and at the last execute step, so dropping it mid-instruction
   // lets the current instruction finish.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state   <= ST_IDLE;
         illegal <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (run) state <= ST_T0;
            ST_T0:   state <= ST_T1;
            ST_T1:   state <= ST_T2;
            ST_T2:   state <= ST_T3;
            ST_T3: begin
               if (op_halt) begin
                  state <= ST_HALT;
               end else if (illegal_op) begin
                  illegal <= 1'b1;
                  state   <= run ? ST_T0 : ST_IDLE;
               end else begin
                  state <= ST_T4;
               end
            end
            ST_T4:   state <= ST_T5;
            ST_T5: begin
               if (op_muldiv) state <= ST_T6;
               else           state <= run ? ST_T0 : ST_IDLE;
            end
            ST_T6:   state <= run ? ST_T0 : ST_IDLE;
            ST_HALT: state <= ST_HALT;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Moore strobe decode. Only one bus driver (Rout bit, Zlowout or
   // MDRout) is ever active per state; fetch states never touch Rin/Rout.
   always_comb begin
      Rin         = 16'd0;
      Rout        = 16'd0;
      PCout       = 1'b0;
      PCin        = 1'b0;
      IncPC       = 1'b0;
      MARin       = 1'b0;
      Read        = 1'b0;
      MDRin       = 1'b0;
      MDRout      = 1'b0;
      IRin        = 1'b0;
      Yin         = 1'b0;
      Zin         = 1'b0;
      Zlowout     = 1'b0;
      Zhighout    = 1'b0;
      HIin        = 1'b0;
      LOin        = 1'b0;
      ALU_Control = 5'd0;
      instr_done  = 1'b0;
      case (state)
         ST_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         ST_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         ST_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            // Unary ops load Y too; the ALU simply ignores it.
            if (op_alu || op_muldiv) begin
               Rout = rb_sel;
               Yin  = 1'b1;
            end
         end
         ST_T4: begin
            if (op_two_src) begin
               Rout        = rc_sel;
               ALU_Control = alu_code(opcode);
               Zin         = 1'b1;
            end else if (op_unary) begin
               Rout        = rb_sel;
               ALU_Control = alu_code(opcode);
               Zin         = 1'b1;
            end
         end
         ST_T5: begin
            if (op_muldiv) begin
               Zlowout = 1'b1;
               LOin    = 1'b1;
            end else if (op_alu) begin
               Zlowout    = 1'b1;
               Rin        = ra_sel;
               instr_done = 1'b1;
            end
         end
         ST_T6: begin
            Zhighout   = 1'b1;
            HIin       = 1'b1;
            instr_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a queue-based instruction model predicts the
// complete output vector for every cycle, plus literal spot checks.
module tb_control_unit;
   import control_pkg::*;

   logic        clock;
   logic        clear;
   logic        run;
   logic [31:0] IR;
   logic [15:0] Rin, Rout;
   logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
   logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
   logic [4:0]  ALU_Control;
   logic        instr_done, illegal, halted;
   state_e      state_dbg;

   control_unit dut (
      .clock       (clock),
      .clear       (clear),
      .run         (run),
      .IR          (IR),
      .Rin         (Rin),
      .Rout        (Rout),
      .PCout       (PCout),
      .PCin        (PCin),
      .IncPC       (IncPC),
      .MARin       (MARin),
      .Read        (Read),
      .MDRin       (MDRin),
      .MDRout      (MDRout),
      .IRin        (IRin),
      .Yin         (Yin),
      .Zin         (Zin),
      .Zlowout     (Zlowout),
      .Zhighout    (Zhighout),
      .HIin        (HIin),
      .LOin        (LOin),
      .ALU_Control (ALU_Control),
      .instr_done  (instr_done),
      .illegal     (illegal),
      .halted      (halted),
      .state_dbg   (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Strobe bits, bit 0 = PCout.
   localparam logic [13:0] SB_PCOUT    = 14'h0001;
   localparam logic [13:0] SB_PCIN     = 14'h0002;
   localparam logic [13:0] SB_INCPC    = 14'h0004;
   localparam logic [13:0] SB_MARIN    = 14'h0008;
   localparam logic [13:0] SB_READ     = 14'h0010;
   localparam logic [13:0] SB_MDRIN    = 14'h0020;
   localparam logic [13:0] SB_MDROUT   = 14'h0040;
   localparam logic [13:0] SB_IRIN     = 14'h0080;
   localparam logic [13:0] SB_YIN      = 14'h0100;
   localparam logic [13:0] SB_ZIN      = 14'h0200;
   localparam logic [13:0] SB_ZLOWOUT  = 14'h0400;
   localparam logic [13:0] SB_ZHIGHOUT = 14'h0800;
   localparam logic [13:0] SB_HIIN     = 14'h1000;
   localparam logic [13:0] SB_LOIN     = 14'h2000;

   logic [13:0] sb;
   logic [53:0] act_vec;
   assign sb = {LOin, HIin, Zhighout, Zlowout, Zin, Yin, IRin, MDRout,
                MDRin, Read, MARin, IncPC, PCin, PCout};
   assign act_vec = {Rin, Rout, sb, ALU_Control, instr_done, illegal, halted};

   // ---------------- program fed to IR ----------------
   logic [31:0] prog [8];
   initial begin
      prog[0] = 32'h08918000;  // add R1, R2, R3
      prog[1] = 32'h112B0000;  // sub R2, R5, R6
      prog[2] = 32'h781A0000;  // mul R3, R4
      prog[3] = 32'h8BC00000;  // neg R7, R8
      prog[4] = 32'hF8000000;  // opcode 31, unsupported
      prog[5] = 32'h80090000;  // div R1, R2
      prog[6] = 32'h112B0000;  // sub, interrupted by clear
      prog[7] = 32'hD8000000;  // halt
   end

   // ---------------- scoreboard / model ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          cmp_en   = 1'b1;
   logic [53:0] exp_q [$];
   logic [53:0] cur;
   logic [31:0] ir_model = 32'd0;
   bit          ill_m = 1'b0;
   bit          hlt_m = 1'b0;
   int          pc = 0;

   function automatic logic [53:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                      input logic [13:0] s, input logic [4:0] alu,
                                      input logic done, input logic ill, input logic hlt);
      return {rin, rout, s, alu, done, ill, hlt};
   endfunction

   // Expand one instruction word into its expected per-cycle outputs.
   task automatic expand(input logic [31:0] w);
      int op, ra, rb, rc;
      bit bin, un, md;
      op  = int'(w[31:27]);
      ra  = int'(w[26:23]);
      rb  = int'(w[22:19]);
      rc  = int'(w[18:15]);
      bin = (op >= 1) && (op <= 8);
      md  = (op == 15) || (op == 16);
      un  = (op == 17) || (op == 18);
      exp_q.push_back(mk(16'd0, 16'd0, SB_PCOUT | SB_MARIN | SB_INCPC | SB_ZIN, 5'd0, 1'b0, ill_m, 1'b0));
      exp_q.push_back(mk(16'd0, 16'd0, SB_ZLOWOUT | SB_PCIN | SB_READ | SB_MDRIN, 5'd0, 1'b0, ill_m, 1'b0));
      exp_q.push_back(mk(16'd0, 16'd0, SB_MDROUT | SB_IRIN, 5'd0, 1'b0, ill_m, 1'b0));
      if (bin || md || un) begin
         exp_q.push_back(mk(16'd0, 16'(1 << rb), SB_YIN, 5'd0, 1'b0, ill_m, 1'b0));
         exp_q.push_back(mk(16'd0, un ? 16'(1 << rb) : 16'(1 << rc), SB_ZIN, 5'(op - 1), 1'b0, ill_m, 1'b0));
         if (md) begin
            exp_q.push_back(mk(16'd0, 16'd0, SB_ZLOWOUT | SB_LOIN, 5'd0, 1'b0, ill_m, 1'b0));
            exp_q.push_back(mk(16'd0, 16'd0, SB_ZHIGHOUT | SB_HIIN, 5'd0, 1'b1, ill_m, 1'b0));
         end else begin
            exp_q.push_back(mk(16'(1 << ra), 16'd0, SB_ZLOWOUT, 5'd0, 1'b1, ill_m, 1'b0));
         end
      end else begin
         exp_q.push_back(mk(16'd0, 16'd0, 14'd0, 5'd0, 1'b0, ill_m, 1'b0));
         if (op == 27) hlt_m = 1'b1;
         else          ill_m = 1'b1;
      end
   endtask

   // Model step: decide what the outputs must be after this edge.
   always @(posedge clock) begin
      if (!clear) begin
         exp_q.delete();
         ill_m = 1'b0;
         hlt_m = 1'b0;
         cur   = mk(16'd0, 16'd0, 14'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      end else if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
      end else if (hlt_m) begin
         cur = mk(16'd0, 16'd0, 14'd0, 5'd0, 1'b0, ill_m, 1'b1);
      end else if (run && pc < 8) begin
         ir_model = prog[pc];
         expand(prog[pc]);
         pc++;
         cur = exp_q.pop_front();
      end else begin
         cur = mk(16'd0, 16'd0, 14'd0, 5'd0, 1'b0, ill_m, 1'b0);
      end
   end

   // Every-cycle comparison of the whole output vector against the model.
   initial begin
      forever begin
         @(negedge clock);
         #2;
         if (cmp_en) begin
            n_checks++;
            if (act_vec !== cur) begin
               n_fail++;
               $display("FAIL cycle @%0t: got 0x%014h expected 0x%014h", $time, act_vec, cur);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clock);
      IR = ir_model;
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      clear = 1'b0;
      run   = 1'b0;
      IR    = 32'd0;
      steps(2);
      chk("reset_strobes", {18'd0, sb}, 32'd0);
      chk("reset_rout", {16'd0, Rout}, 32'd0);
      chk("reset_illegal", {31'd0, illegal}, 32'd0);
      chk("reset_halted", {31'd0, halted}, 32'd0);

      clear = 1'b1;
      run   = 1'b1;
      step();                                  // add T0
      chk("add_t0_pcout", {31'd0, PCout}, 32'd1);
      steps(4);                                // add T4
      chk("add_t4_alu", {27'd0, ALU_Control}, 32'd0);
      chk("add_t4_rout", {16'd0, Rout}, 32'h0008);
      chk("add_t4_zin", {31'd0, Zin}, 32'd1);
      step();                                  // add T5
      chk("add_t5_rin", {16'd0, Rin}, 32'h0002);
      chk("add_t5_done", {31'd0, instr_done}, 32'd1);
      step();                                  // sub T0, no bubble
      chk("b2b_t0_pcout", {31'd0, PCout}, 32'd1);
      chk("b2b_t0_marin", {31'd0, MARin}, 32'd1);
      steps(3);                                // sub T3
      chk("sub_t3_rout", {16'd0, Rout}, 32'h0020);
      chk("sub_t3_yin", {31'd0, Yin}, 32'd1);
      step();                                  // sub T4
      chk("sub_t4_rout", {16'd0, Rout}, 32'h0040);
      chk("sub_t4_alu", {27'd0, ALU_Control}, 32'h01);
      chk("sub_t4_zin", {31'd0, Zin}, 32'd1);
      step();                                  // sub T5
      chk("sub_t5_zlowout", {31'd0, Zlowout}, 32'd1);
      chk("sub_t5_rin", {16'd0, Rin}, 32'h0004);
      chk("sub_t5_done", {31'd0, instr_done}, 32'd1);

      step();                                  // mul T0
      steps(5);                                // mul T5
      chk("mul_t5_zlowout", {31'd0, Zlowout}, 32'd1);
      chk("mul_t5_loin", {31'd0, LOin}, 32'd1);
      chk("mul_t5_rin", {16'd0, Rin}, 32'd0);
      chk("mul_t5_done", {31'd0, instr_done}, 32'd0);
      step();                                  // mul T6
      chk("mul_t6_zhighout", {31'd0, Zhighout}, 32'd1);
      chk("mul_t6_hiin", {31'd0, HIin}, 32'd1);
      chk("mul_t6_done", {31'd0, instr_done}, 32'd1);

      step();                                  // neg T0
      steps(4);                                // neg T4
      chk("neg_t4_rout", {16'd0, Rout}, 32'h0100);
      chk("neg_t4_alu", {27'd0, ALU_Control}, 32'h10);
      step();                                  // neg T5
      chk("neg_t5_rin", {16'd0, Rin}, 32'h0080);

      step();                                  // illegal T0
      steps(3);                                // illegal T3
      chk("ill_t3_yin", {31'd0, Yin}, 32'd0);
      chk("ill_t3_flag", {31'd0, illegal}, 32'd0);
      step();                                  // div T0
      chk("ill_after_flag", {31'd0, illegal}, 32'd1);
      chk("ill_after_pcout", {31'd0, PCout}, 32'd1);

      steps(2);                                // div T2
      run = 1'b0;
      steps(4);                                // div T6
      chk("drop_t6_done", {31'd0, instr_done}, 32'd1);
      step();                                  // IDLE
      chk("drop_idle_strobes", {18'd0, sb}, 32'd0);
      step();
      chk("drop_idle_hold", {31'd0, PCout}, 32'd0);
      run = 1'b1;
      step();                                  // sub T0
      chk("rerun_t0_pcout", {31'd0, PCout}, 32'd1);

      steps(4);                                // sub T4
      chk("pre_clear_zin", {31'd0, Zin}, 32'd1);
      clear = 1'b0;
      step();                                  // IDLE after reset edge
      chk("clear_strobes", {18'd0, sb}, 32'd0);
      chk("clear_rout", {16'd0, Rout}, 32'd0);
      chk("clear_alu", {27'd0, ALU_Control}, 32'd0);
      chk("clear_illegal", {31'd0, illegal}, 32'd0);
      clear = 1'b1;
      step();                                  // halt T0
      chk("post_clear_t0", {31'd0, PCout}, 32'd1);
      steps(3);                                // halt T3
      step();                                  // HALT
      chk("halt_flag", {31'd0, halted}, 32'd1);
      steps(12);
      chk("halt_hold_flag", {31'd0, halted}, 32'd1);
      chk("halt_hold_strobes", {18'd0, sb}, 32'd0);
      chk("halt_hold_done", {31'd0, instr_done}, 32'd0);
      clear = 1'b0;
      step();
      chk("halt_cleared", {31'd0, halted}, 32'd0);

      #3;
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
